mcu_spi: RTL

MCU_SPI -- requirements
Module: mcu_spi

---
 rtl/mcu_spi.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mcu_spi.sv
// SPI slave bridging an MCU link to four byte-wide targets: a target-select byte,
// then command/data bytes strobed to the selected target, with per-byte MISO replies.
module mcu_spi #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_io_ss,
  input  logic       spi_io_clk,
  input  logic       spi_io_din,
  output logic       spi_io_dout,
  output logic       mcu_sys_strobe,
  output logic       mcu_hid_strobe,
  output logic       mcu_osd_strobe,
  output logic       mcu_sdc_strobe,
  output logic       mcu_start,
  output logic [7:0] mcu_dout,
  input  logic [7:0] mcu_sys_din,
  input  logic [7:0] mcu_hid_din,
  input  logic [7:0] mcu_osd_din,
  input  logic [7:0] mcu_sdc_din
);

  typedef enum logic [1:0] {IDLE, TARGET, CMD, DATA} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ss_sync, sck_sync, mosi_sync;
  logic                   ss_d, sck_d;
  logic                   ss_s, sck_s, mosi_s;
  logic                   ss_fall, ss_rise, sck_rise, sck_fall;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx, tx, rx_next, din_sel;
  logic [1:0]             tgt;
  logic                   tgt_valid;
  logic [3:0]             strobes;
  logic                   load_p1, load_p2, reply_p1, reply_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      ss_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_d      <= 1'b1;
      sck_d     <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_io_ss};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_io_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_io_din};
      ss_d      <= ss_s;
      sck_d     <= sck_s;
    end
  end

  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign ss_fall  = ss_d & ~ss_s;
  assign ss_rise  = ~ss_d & ss_s;
  assign sck_rise = ~sck_d & sck_s;
  assign sck_fall = sck_d & ~sck_s;
  assign rx_next  = {rx[6:0], mosi_s};

  always_comb begin
    din_sel = '0;
    case (tgt)
      2'd0:    din_sel = mcu_sys_din;
      2'd1:    din_sel = mcu_hid_din;
      2'd2:    din_sel = mcu_osd_din;
      default: din_sel = mcu_sdc_din;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx        <= '0;
      tx        <= '0;
      mcu_dout  <= '0;
      strobes   <= '0;
      mcu_start <= 1'b0;
      tgt       <= '0;
      tgt_valid <= 1'b0;
      load_p1   <= 1'b0;
      load_p2   <= 1'b0;
      reply_p1  <= 1'b0;
      reply_p2  <= 1'b0;
    end else begin
      strobes   <= '0;
      mcu_start <= 1'b0;
      load_p1   <= 1'b0;
      load_p2   <= load_p1;
      reply_p2  <= reply_p1;

      // Reply is loaded two cycles after byte completion so the target has
      // registered it; falls with bit_cnt==0 are the inter-byte gap and keep the MSB.
      if (load_p2)
        tx <= reply_p2 ? din_sel : '0;
      else if (state != IDLE && sck_fall && bit_cnt != '0)
        tx <= {tx[6:0], 1'b0};

      if (ss_rise) begin
        state   <= IDLE;
        bit_cnt <= '0;
        rx      <= '0;
        tx      <= '0;
        load_p1 <= 1'b0;
        load_p2 <= 1'b0;
      end else if (ss_fall) begin
        state   <= TARGET;
        bit_cnt <= '0;
        rx      <= '0;
      end else if (state != IDLE && sck_rise) begin
        rx      <= rx_next;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          load_p1  <= 1'b1;
          reply_p1 <= 1'b0;
          case (state)
            TARGET: begin
              tgt_valid <= (rx_next[7:2] == 6'd0);
              tgt       <= rx_next[1:0];
              state     <= CMD;
            end
            default: begin
              if (tgt_valid) begin
                mcu_dout     <= rx_next;
                strobes[tgt] <= 1'b1;
                mcu_start    <= (state == CMD);
                reply_p1     <= 1'b1;
              end
              state <= DATA;
            end
          endcase
        end
      end
    end
  end

  assign mcu_sys_strobe = strobes[0];
  assign mcu_hid_strobe = strobes[1];
  assign mcu_osd_strobe = strobes[2];
  assign mcu_sdc_strobe = strobes[3];
  assign spi_io_dout    = tx[7];

endmodule
